fifo_umbral: RTL and testbench
==============================

Name: fifo_umbral

Overview:
- Single synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flag.
- Sits below the transaction-layer control FSM and receives its init pulse and threshold outputs.
- Five instances supply the FSM's 5-bit empty and error status vectors: bit i = instance i's fifo_empty / fifo_error.

Parameters:
- DATA_WIDTH, 6, width of each data word.
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH words (default 4).
- LENGTH, ADDR_WIDTH+1, width of threshold inputs and occupancy count (encodes 0..DEPTH).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  synchronous re-initialisation; connects to FSM init_out.
- umbral_alto  input  LENGTH  almost-full threshold, sampled only while init=1.
- umbral_bajo  input  LENGTH  almost-empty threshold, sampled only while init=1.
- wr_enable  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- rd_enable  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out carries a word read this cycle.
- fifo_empty  output  1  count==0.
- fifo_full  output  1  count==DEPTH.
- almost_full  output  1  count>=latched umbral_alto.
- almost_empty  output  1  count<=latched umbral_bajo.
- fifo_error  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, immediate):
  - wr_ptr, rd_ptr, count cleared to 0; data_out=0; valid_out=0; fifo_error=0.
  - Latched thresholds: alto=DEPTH-1, bajo=1.
  - Resulting flags: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
  - Storage array contents are not reset.
- init=1 at a clock edge has priority over all other requests:
  - Latch umbral_alto and umbral_bajo.
  - Clear pointers, count, fifo_error and valid_out; data_out holds its value.
  - wr_enable and rd_enable are ignored that cycle.
  - Holding init high for multiple cycles repeats this each cycle.
- Write: wr_enable=1 and (count<DEPTH, or count==DEPTH with an accepted read the same cycle):
  - Store data_in at wr_ptr; wr_ptr increments and wraps DEPTH-1 -> 0.
- Overflow: wr_enable=1, count==DEPTH, no accepted read:
  - Word dropped; pointers and count unchanged; fifo_error<=1.
- Read: rd_enable=1 and count>0:
  - data_out<=mem[rd_ptr] and valid_out<=1 at the same edge, i.e. 1-cycle latency from request.
  - rd_ptr increments and wraps.
- Underflow: rd_enable=1 and count==0:
  - No fall-through, even if a write occurs the same cycle.
  - valid_out<=0; data_out holds; fifo_error<=1.
  - A simultaneous write is still accepted.
- valid_out is 0 in any cycle without an accepted read.
- Count update per cycle: +1 (write only), -1 (read only), unchanged (both or neither).
- Status flags are combinational from count and the latched thresholds.
  - Threshold 0 or values above DEPTH are legal, compared unsigned as given.
  - Example: bajo=0 gives almost_empty only when empty; alto>DEPTH means almost_full never asserts.
- fifo_error stays set until reset or init; further errors have no additional effect.
- Data ordering is strict FIFO across pointer wrap-around.

Test Plan:
- Reset check: assert reset mid-cycle -> outputs clear without a clock edge: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, fifo_error=0, valid_out=0, data_out=0.
- Thresholds and fill:
  - init=1 one cycle with umbral_alto=3, umbral_bajo=1; then write 0x11,0x22,0x33,0x04 on consecutive cycles.
  - Expect almost_empty=0 after the 2nd write, almost_full=1 after the 3rd, fifo_full=1 after the 4th, fifo_error=0 throughout.
- Overflow: while full, write 0x3F with no read -> count stays 4, fifo_error=1.
  - Subsequent reads return 0x11,0x22,0x33,0x04, each with valid_out=1 one cycle after its rd_enable.
  - 0x3F never appears.
- Wrap and simultaneity:
  - Write 2 words, read 2, write 4 so pointers wrap.
  - Assert rd_enable and wr_enable together while full -> count stays 4, fifo_error unchanged, order preserved.
- Underflow: empty FIFO, rd_enable=1 with wr_enable=1 and data_in=0x2A -> valid_out=0, fifo_error=1, count=1.
  - The next read returns 0x2A.
- init mid-operation:
  - With 3 words stored and fifo_error=1, pulse init with umbral_alto=2, umbral_bajo=0.
  - Expect fifo_empty=1, fifo_error=0, almost_empty=1.
  - Then write 2 words -> almost_full=1 and almost_empty=0.

Source files
------------

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable almost-full/almost-empty thresholds
// Sticky error flag covers both overflow (write while full) and underflow (read while empty).
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int LENGTH     = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [LENGTH-1:0]     umbral_alto,
  input  logic [LENGTH-1:0]     umbral_bajo,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam int              DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [LENGTH-1:0] L_DEPTH = LENGTH'(DEPTH);
  localparam logic [LENGTH-1:0] L_ALTO0 = LENGTH'(DEPTH - 1);
  localparam logic [LENGTH-1:0] L_BAJO0 = LENGTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [LENGTH-1:0]     r_count;
  logic [LENGTH-1:0]     r_alto;
  logic [LENGTH-1:0]     r_bajo;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_error;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_overflow;
  logic w_underflow;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == L_DEPTH);
  assign w_rd_ok     = rd_enable && !w_empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign w_wr_ok     = wr_enable && (!w_full || w_rd_ok);
  assign w_overflow  = wr_enable && w_full && !w_rd_ok;
  assign w_underflow = rd_enable && w_empty;

  always_ff @(posedge clk) begin
    if (!init && w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_alto      <= L_ALTO0;
      r_bajo      <= L_BAJO0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
    end else if (init) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_alto      <= umbral_alto;
      r_bajo      <= umbral_bajo;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid_out <= w_rd_ok;
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_overflow || w_underflow) begin
        r_error <= 1'b1;
      end
    end
  end

  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;
  assign fifo_error   = r_error;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_full  = (r_count >= r_alto);
  assign almost_empty = (r_count <= r_bajo);

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - scoreboard bench for fifo_umbral against a queue-based reference
// Stimulus updates the model and queues expected read data; a negedge monitor consumes it.
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int LEN   = AW + 1;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [LEN-1:0] umbral_alto;
  logic [LEN-1:0] umbral_bajo;
  logic           wr_enable;
  logic [DW-1:0]  data_in;
  logic           rd_enable;
  logic [DW-1:0]  data_out;
  logic           valid_out;
  logic           fifo_empty;
  logic           fifo_full;
  logic           almost_full;
  logic           almost_empty;
  logic           fifo_error;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LENGTH(LEN)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .wr_enable(wr_enable), .data_in(data_in), .rd_enable(rd_enable),
    .data_out(data_out), .valid_out(valid_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            m_alto = DEPTH - 1;
  int            m_bajo = 1;
  bit            m_err  = 1'b0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(string tag);
    int n = mq.size();
    chk({tag, " fifo_empty"},   int'(fifo_empty),   int'(n == 0));
    chk({tag, " fifo_full"},    int'(fifo_full),    int'(n == DEPTH));
    chk({tag, " almost_full"},  int'(almost_full),  int'(n >= m_alto));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(n <= m_bajo));
    chk({tag, " fifo_error"},   int'(fifo_error),   int'(m_err));
  endtask

  task automatic step(string tag, bit w, logic [DW-1:0] d, bit r,
                      bit in = 1'b0, int a = 0, int b = 0);
    int  n;
    bit  rok;
    wr_enable   = w;
    data_in     = d;
    rd_enable   = r;
    init        = in;
    umbral_alto = LEN'(a);
    umbral_bajo = LEN'(b);
    @(posedge clk);
    if (in) begin
      m_alto = a;
      m_bajo = b;
      mq.delete();
      m_err = 1'b0;
    end else begin
      n   = mq.size();
      rok = r && (n > 0);
      if (rok) exp_q.push_back(mq.pop_front());
      if (w) begin
        if (n < DEPTH || rok) mq.push_back(d);
        else m_err = 1'b1;
      end
      if (r && n == 0) m_err = 1'b1;
    end
    @(negedge clk);
    chk_flags(tag);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    init      = 1'b0;
  endtask

  // Every queued expectation must show up as valid_out exactly at the next negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (valid_out) begin
          if (exp_q.size() == 0) chk("unexpected valid_out", 1, 0);
          else chk("read data", int'(data_out), int'(exp_q.pop_front()));
        end else if (exp_q.size() != 0) begin
          chk("missing valid_out", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; init = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    data_in = '0; umbral_alto = '0; umbral_bajo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_flags("post-reset");
    chk("post-reset valid_out", int'(valid_out), 0);
    chk("post-reset data_out", int'(data_out), 0);

    step("pre underflow", 1'b0, 6'h00, 1'b1);
    step("pre write", 1'b1, 6'h15, 1'b0);
    step("pre read", 1'b0, 6'h00, 1'b1);
    // Asynchronous reset between edges must clear outputs without waiting for a clock.
    #2 reset = 1'b1;
    #1;
    chk("async fifo_empty", int'(fifo_empty), 1);
    chk("async almost_empty", int'(almost_empty), 1);
    chk("async fifo_full", int'(fifo_full), 0);
    chk("async almost_full", int'(almost_full), 0);
    chk("async fifo_error", int'(fifo_error), 0);
    chk("async valid_out", int'(valid_out), 0);
    chk("async data_out", int'(data_out), 0);
    mq.delete(); m_err = 1'b0; m_alto = DEPTH - 1; m_bajo = 1;
    @(negedge clk);
    reset = 1'b0;

    step("init 3/1", 1'b0, 6'h00, 1'b0, 1'b1, 3, 1);
    step("fill 1", 1'b1, 6'h11, 1'b0);
    step("fill 2", 1'b1, 6'h22, 1'b0);
    step("fill 3", 1'b1, 6'h33, 1'b0);
    step("fill 4", 1'b1, 6'h04, 1'b0);
    step("overflow", 1'b1, 6'h3F, 1'b0);
    repeat (4) step("drain", 1'b0, 6'h00, 1'b1);

    step("wrap w", 1'b1, 6'h01, 1'b0);
    step("wrap w", 1'b1, 6'h02, 1'b0);
    repeat (2) step("wrap r", 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 4; i++) step("wrap fill", 1'b1, DW'(6'h10 + i), 1'b0);
    step("full rw", 1'b1, 6'h0A, 1'b1);
    repeat (4) step("wrap drain", 1'b0, 6'h00, 1'b1);

    step("underflow rw", 1'b1, 6'h2A, 1'b1);
    step("read 2A", 1'b0, 6'h00, 1'b1);

    step("err underflow", 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 3; i++) step("three", 1'b1, DW'(6'h20 + i), 1'b0);
    step("init 2/0", 1'b0, 6'h00, 1'b0, 1'b1, 2, 0);
    step("post-init w", 1'b1, 6'h05, 1'b0);
    step("post-init w", 1'b1, 6'h06, 1'b0);

    for (int i = 0; i < 400; i++) begin
      bit in = ($urandom_range(0, 39) == 0);
      step("random", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           in, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
